// File: rtl/reorder_buffer_pkg.sv
// Shared constants and field types for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;

  typedef logic [ID_W-1:0] ROB_ID_TYPE;
  typedef logic [4:0]      REG_TYPE;
  typedef logic [31:0]     DATA_TYPE;
  typedef logic [31:0]     ADDR_TYPE;

  localparam ROB_ID_TYPE ROB_ID_RESET = '0;
  localparam REG_TYPE    REG_RESET    = '0;
  localparam DATA_TYPE   DATA_RESET   = '0;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with mispredict rollback; tag = slot index + 1.
// Optional ROB_DBG_COMMIT_EN adds committed-PC output and a commit counter.
module reorder_buffer
  import reorder_buffer_pkg::REG_TYPE, reorder_buffer_pkg::DATA_TYPE,
         reorder_buffer_pkg::ADDR_TYPE, reorder_buffer_pkg::REG_RESET,
         reorder_buffer_pkg::DATA_RESET;
#(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int ID_W     = reorder_buffer_pkg::ID_W
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            alloc_valid_in,
  input  REG_TYPE         alloc_rd_in,
  input  ADDR_TYPE        alloc_pc_in,
  input  logic            alloc_is_branch_in,
  output logic [ID_W-1:0] alloc_id_out,
  output logic            full_out,
  input  logic            wb_valid_in,
  input  logic [ID_W-1:0] wb_rob_id_in,
  input  DATA_TYPE        wb_value_in,
  input  logic            wb_mispredict_in,
  input  ADDR_TYPE        wb_target_in,
  output logic            commit_flag_out,
  output REG_TYPE         rd_to_reg_out,
  output DATA_TYPE        V_to_reg_out,
  output logic [ID_W-1:0] Q_to_reg_out,
  output logic            rollback_flag_out,
  output ADDR_TYPE        rollback_pc_out
`ifdef ROB_DBG_COMMIT_EN
  ,
  output ADDR_TYPE        dbg_commit_pos_out
`endif
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ID_W-1:0]  tag_t;

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_is_branch;
  logic [ROB_SIZE-1:0] r_mispred;
  REG_TYPE             r_rd     [ROB_SIZE];
  DATA_TYPE            r_value  [ROB_SIZE];
  ADDR_TYPE            r_target [ROB_SIZE];

  idx_t r_head;
  idx_t r_tail;
  cnt_t r_count;

  logic w_commit;
  logic w_rollback;
  logic w_alloc;
  logic w_wb_hit;
  idx_t w_wb_idx;

  assign full_out     = (r_count == cnt_t'(ROB_SIZE));
  assign alloc_id_out = tag_t'(r_tail) + tag_t'(1);

  // Commit reads only registered ready bits, so a writeback to the head
  // always waits at least one edge before it can retire.
  always_comb begin
    w_commit   = rdy_in & r_busy[r_head] & r_ready[r_head];
    w_rollback = w_commit & r_is_branch[r_head] & r_mispred[r_head];
    w_alloc    = rdy_in & alloc_valid_in & ~full_out;
    w_wb_idx   = idx_t'(wb_rob_id_in - tag_t'(1));
    w_wb_hit   = rdy_in & wb_valid_in & (wb_rob_id_in != '0) &
                 (wb_rob_id_in <= tag_t'(ROB_SIZE)) & r_busy[w_wb_idx];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy            <= '0;
      r_ready           <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      commit_flag_out   <= 1'b0;
      rd_to_reg_out     <= REG_RESET;
      V_to_reg_out      <= DATA_RESET;
      Q_to_reg_out      <= '0;
      rollback_flag_out <= 1'b0;
      rollback_pc_out   <= DATA_RESET;
    end else begin
      commit_flag_out   <= w_commit;
      rollback_flag_out <= w_rollback;
      if (w_commit) begin
        rd_to_reg_out <= r_rd[r_head];
        V_to_reg_out  <= r_value[r_head];
        Q_to_reg_out  <= tag_t'(r_head) + tag_t'(1);
      end
      if (w_rollback) begin
        // Flush everything, including any allocation offered this cycle.
        rollback_pc_out <= r_target[r_head];
        r_busy          <= '0;
        r_ready         <= '0;
        r_head          <= '0;
        r_tail          <= '0;
        r_count         <= '0;
      end else begin
        if (w_wb_hit) begin
          r_ready[w_wb_idx]   <= 1'b1;
          r_value[w_wb_idx]   <= wb_value_in;
          r_mispred[w_wb_idx] <= wb_mispredict_in;
          r_target[w_wb_idx]  <= wb_target_in;
        end
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + idx_t'(1);
        end
        if (w_alloc) begin
          r_busy[r_tail]      <= 1'b1;
          r_ready[r_tail]     <= 1'b0;
          r_rd[r_tail]        <= alloc_rd_in;
          r_is_branch[r_tail] <= alloc_is_branch_in;
          r_tail              <= r_tail + idx_t'(1);
        end
        r_count <= r_count + cnt_t'(w_alloc) - cnt_t'(w_commit);
      end
    end
  end

`ifdef ROB_DBG_COMMIT_EN
  ADDR_TYPE    r_pc [ROB_SIZE];
  logic [31:0] r_dbg_commit_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dbg_commit_pos_out <= DATA_RESET;
      r_dbg_commit_cnt   <= '0;
    end else begin
      if (w_alloc && !w_rollback) begin
        r_pc[r_tail] <= alloc_pc_in;
      end
      if (w_commit) begin
        dbg_commit_pos_out <= r_pc[r_head];
        r_dbg_commit_cnt   <= r_dbg_commit_cnt + 32'd1;
      end
    end
  end
`else
  // The PC is only observable through the debug port.
  logic w_unused_pc;
  assign w_unused_pc = ^alloc_pc_in;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table, hand-written corner sequences and a
// randomized scoreboard phase checking in-order retirement.
module tb_reorder_buffer;

  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;
  localparam int SBW      = 75;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic            alloc_valid_in;
  logic [4:0]      alloc_rd_in;
  logic [31:0]     alloc_pc_in;
  logic            alloc_is_branch_in;
  logic [ID_W-1:0] alloc_id_out;
  logic            full_out;
  logic            wb_valid_in;
  logic [ID_W-1:0] wb_rob_id_in;
  logic [31:0]     wb_value_in;
  logic            wb_mispredict_in;
  logic [31:0]     wb_target_in;
  logic            commit_flag_out;
  logic [4:0]      rd_to_reg_out;
  logic [31:0]     V_to_reg_out;
  logic [ID_W-1:0] Q_to_reg_out;
  logic            rollback_flag_out;
  logic [31:0]     rollback_pc_out;
`ifdef ROB_DBG_COMMIT_EN
  logic [31:0]     dbg_commit_pos_out;
`endif

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
    .alloc_pc_in(alloc_pc_in), .alloc_is_branch_in(alloc_is_branch_in),
    .alloc_id_out(alloc_id_out), .full_out(full_out),
    .wb_valid_in(wb_valid_in), .wb_rob_id_in(wb_rob_id_in),
    .wb_value_in(wb_value_in), .wb_mispredict_in(wb_mispredict_in),
    .wb_target_in(wb_target_in), .commit_flag_out(commit_flag_out),
    .rd_to_reg_out(rd_to_reg_out), .V_to_reg_out(V_to_reg_out),
    .Q_to_reg_out(Q_to_reg_out), .rollback_flag_out(rollback_flag_out),
    .rollback_pc_out(rollback_pc_out)
`ifdef ROB_DBG_COMMIT_EN
    , .dbg_commit_pos_out(dbg_commit_pos_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [SBW-1:0] got,
                       input logic [SBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    alloc_valid_in = 1'b0; alloc_rd_in = '0; alloc_pc_in = '0;
    alloc_is_branch_in = 1'b0; wb_valid_in = 1'b0; wb_rob_id_in = '0;
    wb_value_in = '0; wb_mispredict_in = 1'b0; wb_target_in = '0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic drive_alloc(input logic [4:0] rd, input logic [31:0] pc,
                             input logic br);
    alloc_valid_in = 1'b1; alloc_rd_in = rd; alloc_pc_in = pc;
    alloc_is_branch_in = br;
  endtask

  task automatic drive_wb(input logic [ID_W-1:0] tag, input logic [31:0] val,
                          input logic mis, input logic [31:0] tgt);
    wb_valid_in = 1'b1; wb_rob_id_in = tag; wb_value_in = val;
    wb_mispredict_in = mis; wb_target_in = tgt;
  endtask

  task automatic do_reset();
    set_idle(); rdy_in = 1'b1; rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic check_commit(input string name, input logic [4:0] rd,
                              input logic [31:0] v, input logic [ID_W-1:0] q);
    check({name, "_flag"}, SBW'(commit_flag_out), SBW'(1));
    check({name, "_rd"}, SBW'(rd_to_reg_out), SBW'(rd));
    check({name, "_v"}, SBW'(V_to_reg_out), SBW'(v));
    check({name, "_q"}, SBW'(Q_to_reg_out), SBW'(q));
  endtask

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] sb_exp;
  logic           sb_en = 1'b0;
  int             m_count = 0;
  int             n_commits = 0;

  always @(negedge clk_in) begin
    if (sb_en && !rst_in && commit_flag_out) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_commit", SBW'(Q_to_reg_out), SBW'(0));
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_commit", {rd_to_reg_out, V_to_reg_out, Q_to_reg_out,
                            rollback_flag_out, rollback_pc_out}, sb_exp);
      end
      m_count--;
      n_commits++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic            av;
    logic [4:0]      rd;
    logic [31:0]     pc;
    logic            wv;
    logic [ID_W-1:0] wid;
    logic [31:0]     wval;
    logic [ID_W-1:0] e_id;
    logic            e_full;
    logic            e_cf;
    logic [4:0]      e_rd;
    logic [31:0]     e_v;
    logic [ID_W-1:0] e_q;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] rd,
                              input logic [31:0] pc, input logic wv,
                              input logic [ID_W-1:0] wid, input logic [31:0] wval,
                              input logic [ID_W-1:0] e_id, input logic e_cf,
                              input logic [4:0] e_rd, input logic [31:0] e_v,
                              input logic [ID_W-1:0] e_q);
    vec_t v;
    v.av = av; v.rd = rd; v.pc = pc; v.wv = wv; v.wid = wid; v.wval = wval;
    v.e_id = e_id; v.e_full = 1'b0; v.e_cf = e_cf; v.e_rd = e_rd;
    v.e_v = e_v; v.e_q = e_q;
    return v;
  endfunction

  vec_t tbl[19];

  logic [31:0] m_val [1:ROB_SIZE];
  int          pending[$];
  int          m_tail;
  int          n_alloc;

  initial begin
    // Each row: inputs for one edge, expected outputs after that edge.
    tbl[0]  = mk(1, 5, 32'h100, 0, 0, 0,           2, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,       1, 1, 32'hDEAD,    2, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,       0, 0, 0,           2, 1, 5, 32'hDEAD, 1);
    tbl[3]  = mk(0, 0, 0,       0, 0, 0,           2, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 32'h104, 0, 0, 0,           3, 0, 0, 0, 0);
    tbl[5]  = mk(1, 2, 32'h108, 0, 0, 0,           4, 0, 0, 0, 0);
    tbl[6]  = mk(1, 3, 32'h10C, 0, 0, 0,           5, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,       1, 4, 32'h44,      5, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,       1, 3, 32'h33,      5, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,       1, 2, 32'h22,      5, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,       0, 0, 0,           5, 1, 1, 32'h22, 2);
    tbl[11] = mk(0, 0, 0,       0, 0, 0,           5, 1, 2, 32'h33, 3);
    tbl[12] = mk(0, 0, 0,       0, 0, 0,           5, 1, 3, 32'h44, 4);
    tbl[13] = mk(0, 0, 0,       1, 5, 32'h99,      5, 0, 0, 0, 0);
    tbl[14] = mk(1, 7, 32'h110, 0, 0, 0,           6, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0,       0, 0, 0,           6, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,       1, 5, 32'h55,      6, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0,       0, 0, 0,           6, 1, 7, 32'h55, 5);
    tbl[18] = mk(0, 0, 0,       1, 0, 32'h77,      6, 0, 0, 0, 0);

    rst_in = 1'b1; rdy_in = 1'b1; set_idle();
    do_reset();
    check("reset_alloc_id", SBW'(alloc_id_out), SBW'(1));
    check("reset_full", SBW'(full_out), SBW'(0));
    check("reset_commit_flag", SBW'(commit_flag_out), SBW'(0));
    check("reset_rollback_flag", SBW'(rollback_flag_out), SBW'(0));

    for (int i = 0; i < 19; i++) begin
      set_idle();
      if (tbl[i].av) drive_alloc(tbl[i].rd, tbl[i].pc, 1'b0);
      if (tbl[i].wv) drive_wb(tbl[i].wid, tbl[i].wval, 1'b0, 32'h0);
      tick();
      check($sformatf("vec%0d_alloc_id", i), SBW'(alloc_id_out), SBW'(tbl[i].e_id));
      check($sformatf("vec%0d_full", i), SBW'(full_out), SBW'(tbl[i].e_full));
      if (tbl[i].e_cf)
        check_commit($sformatf("vec%0d_commit", i), tbl[i].e_rd, tbl[i].e_v, tbl[i].e_q);
      else
        check($sformatf("vec%0d_flag", i), SBW'(commit_flag_out), SBW'(0));
    end

    // Fill, overflow, wrap, no pass-through on a full cycle.
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      set_idle(); drive_alloc(5'(i), 32'h1000 + 32'(i), 1'b0);
      tick();
      check($sformatf("fill%0d_id", i), SBW'(alloc_id_out), SBW'(((i + 1) % ROB_SIZE) + 1));
      check($sformatf("fill%0d_full", i), SBW'(full_out), SBW'(i == ROB_SIZE - 1));
    end
    tick();
    check("overflow_id", SBW'(alloc_id_out), SBW'(1));
    check("overflow_full", SBW'(full_out), SBW'(1));
    drive_wb(1, 32'hA1, 1'b0, 32'h0);
    tick();
    check("full_wb_flag", SBW'(commit_flag_out), SBW'(0));
    wb_valid_in = 1'b0;
    tick();
    check_commit("full_commit", 5'd0, 32'hA1, 5'd1);
    check("no_passthru_full", SBW'(full_out), SBW'(0));
    check("no_passthru_id", SBW'(alloc_id_out), SBW'(1));
    tick();
    check("wrap_refill_full", SBW'(full_out), SBW'(1));
    check("wrap_refill_id", SBW'(alloc_id_out), SBW'(2));
    set_idle(); drive_wb(2, 32'hB2, 1'b0, 32'h0);
    tick();
    // Reset with a ready head in flight: nothing may retire.
    do_reset();
    check("midreset_alloc_id", SBW'(alloc_id_out), SBW'(1));
    check("midreset_full", SBW'(full_out), SBW'(0));
    check("midreset_outputs", {commit_flag_out, rd_to_reg_out, V_to_reg_out, Q_to_reg_out},
          SBW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_no_commit", SBW'(commit_flag_out), SBW'(0));
    end

    // Mispredict rollback with younger entries in flight.
    do_reset();
    drive_alloc(1, 32'h300, 1'b0); tick();
    drive_alloc(2, 32'h304, 1'b1); tick();
    drive_alloc(3, 32'h308, 1'b0); tick();
    drive_alloc(4, 32'h30C, 1'b0); tick();
    set_idle(); drive_wb(1, 32'h11, 1'b0, 32'h0); tick();
    drive_wb(2, 32'h22, 1'b1, 32'h200); tick();
    check_commit("rb_first", 5'd1, 32'h11, 5'd1);
    check("rb_first_no_rollback", SBW'(rollback_flag_out), SBW'(0));
    drive_wb(3, 32'h33, 1'b0, 32'h0);
    drive_alloc(9, 32'h400, 1'b0);
    tick();
    check_commit("rb_branch", 5'd2, 32'h22, 5'd2);
    check("rb_flag", SBW'(rollback_flag_out), SBW'(1));
    check("rb_pc", SBW'(rollback_pc_out), SBW'(32'h200));
    check("rb_alloc_id", SBW'(alloc_id_out), SBW'(1));
    check("rb_full", SBW'(full_out), SBW'(0));
    set_idle(); drive_wb(3, 32'h33, 1'b0, 32'h0); tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rb_no_stale_commit", SBW'(commit_flag_out), SBW'(0));
      check("rb_flag_cleared", SBW'(rollback_flag_out), SBW'(0));
    end

    // Freeze via rdy_in with a ready head.
    do_reset();
    drive_alloc(9, 32'h500, 1'b0); tick();
    set_idle(); drive_wb(1, 32'hBEEF, 1'b0, 32'h0); tick();
    set_idle(); rdy_in = 1'b0; drive_alloc(3, 32'h504, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_no_commit", SBW'(commit_flag_out), SBW'(0));
      check("freeze_alloc_id", SBW'(alloc_id_out), SBW'(2));
    end
    set_idle(); rdy_in = 1'b1;
    tick();
    check_commit("freeze_resume", 5'd9, 32'hBEEF, 5'd1);
    tick();
    check("freeze_after", SBW'(commit_flag_out), SBW'(0));

    // Randomized traffic against the scoreboard.
    do_reset();
    exp_q.delete(); pending.delete();
    m_count = 0; m_tail = 0; n_alloc = 0; n_commits = 0;
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      set_idle();
      if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
        int k;
        int t;
        k = $urandom_range(0, pending.size() - 1);
        t = pending[k];
        pending.delete(k);
        drive_wb(ID_W'(t), m_val[t], 1'b0, 32'h0);
      end
      if (m_count < ROB_SIZE && $urandom_range(0, 1) == 1) begin
        logic [4:0]  rd;
        logic [31:0] val;
        int          tag;
        rd  = 5'($urandom_range(0, 31));
        val = $urandom;
        tag = m_tail + 1;
        m_val[tag] = val;
        drive_alloc(rd, 32'h2000 + 32'(cyc), 1'b0);
        exp_q.push_back({rd, val, ID_W'(tag), 1'b0, 32'h0});
        pending.push_back(tag);
        m_tail = (m_tail + 1) % ROB_SIZE;
        m_count++;
        n_alloc++;
      end
      tick();
    end
    set_idle();
    while (pending.size() > 0) begin
      int t;
      t = pending.pop_front();
      drive_wb(ID_W'(t), m_val[t], 1'b0, 32'h0);
      tick();
    end
    set_idle();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    tick();
    check("sb_drain", SBW'(exp_q.size()), SBW'(0));
    check("sb_count", SBW'(n_commits), SBW'(n_alloc));
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
